// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared stage indices and per-stage entry metadata for the control pipeline.
package ctrl_pipe_pkg;
   localparam int STG_E = 0;
   localparam int STG_M = 1;
   localparam int STG_W = 2;
   typedef struct packed {
      logic valid;
      logic branch;
      logic jump;
      logic pred_taken;
   } meta_t;
endpackage

// File: rtl/module_ctrl_stage_reg.sv
// module_ctrl_stage_reg: one pipeline entry with flush > hold > bubble > load priority.
module module_ctrl_stage_reg
   import ctrl_pipe_pkg::*;
#(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             hold,
   input  logic             bubble,
   input  meta_t            d_meta,
   input  logic [WIDTH-1:0] d_ctrl,
   output meta_t            q_meta,
   output logic [WIDTH-1:0] q_ctrl
);
   // invalid entries are forced to all-zero so downstream never needs gating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_meta <= '0;
         q_ctrl <= '0;
      end else if (flush) begin
         q_meta <= '0;
         q_ctrl <= '0;
      end else if (!hold) begin
         q_meta <= (bubble || !d_meta.valid) ? '0 : d_meta;
         q_ctrl <= (bubble || !d_meta.valid) ? '0 : d_ctrl;
      end
   end
endmodule

// File: rtl/module_ctrl_pipe.sv
// module_ctrl_pipe: control-bundle pipeline with stall chain, branch resolution,
// mispredict auto-flush and saturating branch statistics.
module module_ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int STAGES        = 3,
   parameter int WIDTH         = 11,
   parameter int RESOLVE_STAGE = 0,
   parameter bit AUTO_FLUSH    = 1'b1,
   parameter int CNT_W         = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   input  logic [WIDTH-1:0]        in_ctrl_i,
   input  logic                    in_branch_i,
   input  logic                    in_jump_i,
   input  logic                    in_pred_taken_i,
   output logic                    in_ready_o,
   input  logic [STAGES-1:0]       stall_i,
   input  logic [STAGES-1:0]       flush_i,
   input  logic                    cond_i,
   input  logic                    clr_cnt_i,
   output logic [STAGES-1:0]       stage_valid_o,
   output logic [STAGES*WIDTH-1:0] stage_ctrl_o,
   output logic                    pcsrc_o,
   output logic                    mispredict_o,
   output logic                    btb_we_o,
   output logic [CNT_W-1:0]        br_cnt_o,
   output logic [CNT_W-1:0]        mp_cnt_o
);
   meta_t            meta [STAGES];
   logic [WIDTH-1:0] ctrl [STAGES];
   logic [STAGES-1:0] stall_eff;
   meta_t            res;
   logic             auto_flush;
   meta_t            in_meta;
   always_comb begin
      stall_eff[STAGES-1] = stall_i[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) stall_eff[k] = stall_i[k] | stall_eff[k+1];
   end
   assign in_ready_o   = !stall_eff[0];
   assign res          = meta[RESOLVE_STAGE];
   assign pcsrc_o      = res.valid & ((res.branch & cond_i) | res.jump);
   assign mispredict_o = res.valid & (res.branch | res.jump) & (pcsrc_o != res.pred_taken);
   assign btb_we_o     = res.valid & (res.branch | res.jump) & !stall_eff[RESOLVE_STAGE]
                         & !flush_i[RESOLVE_STAGE];
   assign auto_flush   = AUTO_FLUSH & mispredict_o & !stall_eff[RESOLVE_STAGE];
   // a redirect drops the wrong-path Decode entry as well as younger stages
   assign in_meta      = auto_flush ? '0 :
                         '{valid: in_valid_i, branch: in_branch_i, jump: in_jump_i,
                           pred_taken: in_pred_taken_i};
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      module_ctrl_stage_reg #(.WIDTH(WIDTH)) u_reg (
         .clk    (clk_i),
         .rst    (rst_i),
         .flush  (flush_i[k] | (auto_flush & (k < RESOLVE_STAGE))),
         .hold   (stall_eff[k]),
         .bubble ((k > 0) ? stall_eff[(k > 0) ? k-1 : 0] : 1'b0),
         .d_meta ((k > 0) ? meta[(k > 0) ? k-1 : 0] : in_meta),
         .d_ctrl ((k > 0) ? ctrl[(k > 0) ? k-1 : 0] : in_ctrl_i),
         .q_meta (meta[k]),
         .q_ctrl (ctrl[k])
      );
      assign stage_valid_o[k]              = meta[k].valid;
      assign stage_ctrl_o[k*WIDTH +: WIDTH] = ctrl[k];
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         br_cnt_o <= '0;
         mp_cnt_o <= '0;
      end else if (clr_cnt_i) begin
         br_cnt_o <= '0;
         mp_cnt_o <= '0;
      end else if (btb_we_o) begin
         if (br_cnt_o != '1) br_cnt_o <= br_cnt_o + CNT_W'(1);
         if (mispredict_o && mp_cnt_o != '1) mp_cnt_o <= mp_cnt_o + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_module_ctrl_pipe.sv
// tb_module_ctrl_pipe: directed checks of flow, backpressure, flush, resolution and counters.
module tb_module_ctrl_pipe;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i, in_branch_i, in_jump_i, in_pred_taken_i, cond_i, clr_cnt_i;
   logic [10:0] in_ctrl_i;
   logic [2:0]  stall_i, flush_i, stage_valid_o;
   logic [32:0] stage_ctrl_o;
   logic        in_ready_o, pcsrc_o, mispredict_o, btb_we_o;
   logic [3:0]  br_cnt_o, mp_cnt_o;
   int          vectors = 0;
   int          miscompares = 0;

   module_ctrl_pipe #(.STAGES(3), .WIDTH(11), .RESOLVE_STAGE(0), .AUTO_FLUSH(1'b1), .CNT_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ctrl_i(in_ctrl_i),
      .in_branch_i(in_branch_i), .in_jump_i(in_jump_i), .in_pred_taken_i(in_pred_taken_i),
      .in_ready_o(in_ready_o), .stall_i(stall_i), .flush_i(flush_i), .cond_i(cond_i),
      .clr_cnt_i(clr_cnt_i), .stage_valid_o(stage_valid_o), .stage_ctrl_o(stage_ctrl_o),
      .pcsrc_o(pcsrc_o), .mispredict_o(mispredict_o), .btb_we_o(btb_we_o),
      .br_cnt_o(br_cnt_o), .mp_cnt_o(mp_cnt_o));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [10:0] c, input logic b, input logic j,
                        input logic p);
      in_valid_i = v; in_ctrl_i = c; in_branch_i = b; in_jump_i = j; in_pred_taken_i = p;
   endtask

   initial begin
      rst_i = 1'b1; stall_i = '0; flush_i = '0; cond_i = 1'b0; clr_cnt_i = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #3;
      chk("rst_valid", stage_valid_o, 0);
      chk("rst_ctrl", stage_ctrl_o, 0);
      chk("rst_br", br_cnt_o, 0);
      chk("rst_mp", mp_cnt_o, 0);
      chk("rst_pcsrc", {pcsrc_o, mispredict_o, btb_we_o}, 0);
      chk("rst_ready", in_ready_o, 1);
      #9 rst_i = 1'b0;
      // flow of a single entry
      drive(1'b1, 11'h5A5, 1'b0, 1'b0, 1'b0);
      tick(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("flow_s0_v", stage_valid_o, 3'b001);
      chk("flow_s0_c", stage_ctrl_o, 33'h5A5);
      tick();
      chk("flow_s1_v", stage_valid_o, 3'b010);
      chk("flow_s1_c", stage_ctrl_o, 33'h5A5 << 11);
      tick();
      chk("flow_s2_v", stage_valid_o, 3'b100);
      chk("flow_s2_c", stage_ctrl_o, 33'h5A5 << 22);
      tick();
      chk("flow_out", {stage_valid_o, stage_ctrl_o}, 0);
      // backpressure on stage 1
      drive(1'b1, 11'h001, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 11'h002, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 11'h003, 1'b0, 1'b0, 1'b0); stall_i = 3'b010; #1;
      chk("bp_ready", in_ready_o, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("bp_hold_v", stage_valid_o, 3'b011);
         chk("bp_hold_c", stage_ctrl_o, (33'h001 << 11) | 33'h002);
      end
      stall_i = '0; #1;
      chk("bp_ready_rel", in_ready_o, 1);
      tick(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("bp_rel_c", stage_ctrl_o, (33'h001 << 22) | (33'h002 << 11) | 33'h003);
      tick();
      chk("bp_drain1", stage_ctrl_o, (33'h002 << 22) | (33'h003 << 11));
      tick();
      chk("bp_drain2", {stage_valid_o, stage_ctrl_o}, {3'b100, 33'h003 << 22});
      tick();
      // flush wins over stall
      drive(1'b1, 11'h7FF, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("fl_load", stage_valid_o, 3'b001);
      stall_i = 3'b001; flush_i = 3'b001; #1;
      chk("fl_ready", in_ready_o, 0);
      tick();
      chk("fl_clear", {stage_valid_o, stage_ctrl_o}, 0);
      stall_i = '0; flush_i = '0;
      // mispredict at stage 0 drops the Decode entry
      drive(1'b1, 11'h0AB, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 11'h155, 1'b0, 1'b0, 1'b0); cond_i = 1'b1; #1;
      chk("mp_flags", {pcsrc_o, mispredict_o, btb_we_o}, 3'b111);
      tick(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0); cond_i = 1'b0; #1;
      chk("mp_drop", {stage_valid_o, stage_ctrl_o}, {3'b010, 33'h0AB << 11});
      chk("mp_br", br_cnt_o, 1);
      chk("mp_mp", mp_cnt_o, 1);
      chk("mp_once", {pcsrc_o, btb_we_o}, 0);
      clr_cnt_i = 1'b1; tick(); clr_cnt_i = 1'b0;
      chk("clr_cnt", {br_cnt_o, mp_cnt_o}, 0);
      tick();
      // correctly predicted jump held under stall
      drive(1'b1, 11'h321, 1'b0, 1'b1, 1'b1); tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0); stall_i = 3'b001;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("st_btb_we", btb_we_o, 0);
         chk("st_flags", {pcsrc_o, mispredict_o}, 2'b10);
         tick();
      end
      stall_i = '0; #1;
      chk("st_rel_we", btb_we_o, 1);
      tick();
      chk("st_cnt", {br_cnt_o, mp_cnt_o}, {4'd1, 4'd0});
      // counter saturation
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 11'(i), 1'b1, 1'b0, 1'b0);
         tick();
         if (i == 9) chk("sat_mid", br_cnt_o, 4'hA);
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick(); tick();
      chk("sat_br", br_cnt_o, 4'hF);
      chk("sat_mp", mp_cnt_o, 4'h0);
      // asynchronous reset mid-flow
      drive(1'b1, 11'h0F0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 11'h0F1, 1'b0, 1'b1, 1'b0); tick();
      chk("pre_rst_flags", {stage_valid_o, pcsrc_o, mispredict_o}, {3'b011, 2'b11});
      #2 rst_i = 1'b1; #1;
      chk("arst_valid", stage_valid_o, 0);
      chk("arst_ctrl", stage_ctrl_o, 0);
      chk("arst_flags", {pcsrc_o, mispredict_o, btb_we_o}, 0);
      chk("arst_cnt", {br_cnt_o, mp_cnt_o}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/module_ctrl_pipe.md
# module_ctrl_pipe

Parametrised control-signal pipeline for the RV32I core: carries the decoded control bundle from Decode through a configurable number of downstream stages, with a per-stage stall/flush, valid bits, and branch resolution with misprediction detection against the branch predictor's guess. It sits between the main/ALU decoders and the datapath/hazard unit. It generalises the fixed E/M/W control registers with:
- arbitrary stage count and bundle width;
- backpressure;
- optional self-flush on mispredict;
- saturating branch/mispredict statistics counters.

## Interface
- STAGES, 3, number of pipeline stages after Decode (stage 0 = Execute); legal 2..8
- WIDTH, 11, control bundle width per stage
- RESOLVE_STAGE, 0, stage index where branches/jumps resolve; legal 0..STAGES-1
- AUTO_FLUSH, 1, 1 = a mispredict flushes stages younger than RESOLVE_STAGE and the incoming Decode entry
- CNT_W, 16, statistics counter width
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  Decode entry valid
- in_ctrl_i  in  WIDTH  Decode control bundle
- in_branch_i  in  1  entry is conditional branch
- in_jump_i  in  1  entry is jal/jalr
- in_pred_taken_i  in  1  predictor's taken guess for entry
- in_ready_o  out  1  stage 0 accepts this cycle
- stall_i  in  STAGES  per-stage stall request
- flush_i  in  STAGES  per-stage flush request
- cond_i  in  1  branch condition true at RESOLVE_STAGE (e.g. Zero)
- clr_cnt_i  in  1  synchronous counter clear
- stage_valid_o  out  STAGES  valid bit per stage
- stage_ctrl_o  out  STAGES*WIDTH  bundle per stage, stage k at bits [k*WIDTH +: WIDTH]
- pcsrc_o  out  1  redirect PC to target (actual taken)
- mispredict_o  out  1  resolved outcome differs from prediction
- btb_we_o  out  1  write predictor/BTB this cycle
- br_cnt_o  out  CNT_W  resolved branch/jump count
- mp_cnt_o  out  CNT_W  mispredict count

## Operation
- Stage entry: valid, bundle, branch, jump, pred_taken.
- Effective stall: stall_eff[k] = stall_i[k] | stall_eff[k+1]; stall_eff[STAGES-1] = stall_i[STAGES-1]. in_ready_o = !stall_eff[0].
- Each edge, per stage k:
  - flush_i[k] (or auto-flush) clears the whole entry to zero; flush wins over stall.
  - Otherwise stall_eff[k] holds the entry.
  - Otherwise, if stall_eff[k-1] (k>0), a bubble is loaded: all-zero entry.
  - Otherwise the entry is loaded from stage k-1, or from in_* for stage 0.
- Invalid entries always carry an all-zero bundle; stage_ctrl_o is never gated externally.
- Resolve stage R, with entry e:
  - taken = e.valid & ((e.branch & cond_i) | e.jump)
  - pcsrc_o = taken
  - mispredict_o = e.valid & (e.branch|e.jump) & (taken != e.pred_taken)
  - btb_we_o = e.valid & (e.branch|e.jump) & !stall_eff[R] & !flush_i[R], so it fires exactly once per instruction.
- AUTO_FLUSH=1 and mispredict_o & !stall_eff[R]:
  - stages 0..R-1 are cleared at the next edge;
  - stage 0 does not capture in_*.
  - With R=0 only the incoming entry is dropped.
- Counters:
  - br_cnt increments when btb_we_o = 1; mp_cnt increments when btb_we_o & mispredict_o.
  - Both saturate at all-ones.
  - clr_cnt_i zeroes both and has priority over increment.

## Timing
- Reset: every stage entry, stage_valid_o, stage_ctrl_o, br_cnt_o and mp_cnt_o are 0, so pcsrc_o, mispredict_o and btb_we_o are 0. Reset mid-operation drops all in-flight entries immediately (asynchronous).
- Latency: one cycle per stage. An entry accepted at edge n is in stage k after edge n+k, if not stalled.
- pcsrc_o, mispredict_o, btb_we_o and in_ready_o are combinational from current state plus cond_i/stall_i/flush_i; there is no path from in_* to any output.
- Simultaneous events:
  - flush_i[k] with stall_i[k]: stage k cleared and stages below still stall.
  - Mispredict while stall_eff[R]: no auto-flush and no counter update until the stall releases.
- The last stage drains every cycle unless stalled.

## Structure
- Shared package ctrl_pipe_pkg:
  - stage index constants STG_E=0, STG_M=1, STG_W=2;
  - typedef struct packed for the entry metadata (valid, branch, jump, pred_taken).
- Sub-module module_ctrl_stage_reg holds one entry, with WIDTH parameter, async reset, hold/flush/bubble/load priority. It is instantiated STAGES times via generate.
- Effective stall chain, resolution logic and counters live in the top.

## Test plan
- Flow: STAGES=3, no stalls, in_valid_i=1 with in_ctrl_i=11'h5A5 at edge 0 → stage_ctrl_o stage 0/1/2 shows 11'h5A5 after edges 1/2/3, then 0.
- Backpressure: stall_i=3'b010 for 2 cycles → stages 0,1 hold, stage 2 valid=0 (bubble), in_ready_o=0; on release, order is preserved.
- Flush vs stall: stall_i[0]=1 and flush_i[0]=1 together → stage 0 valid=0, bundle 0, in_ready_o=0.
- Mispredict: branch with pred_taken=0 and cond_i=1 at R=0 → pcsrc_o=1, mispredict_o=1, btb_we_o=1 for one cycle. With AUTO_FLUSH=1 the Decode entry is dropped; br_cnt=1, mp_cnt=1.
- Correct predict under stall: jump with pred_taken=1, stall_i[0]=1 for 3 cycles → btb_we_o=0 while stalled, 1 once on release; br_cnt=1, mp_cnt=0.
- Saturation/reset: CNT_W=4, 20 resolved branches → br_cnt_o=4'hF. clr_cnt_i → 0. Asserting rst_i mid-flow → all outputs 0 within the same cycle.
